// File: rtl/irq_gateway_rx.sv
// Interrupt gateway: turns per-source level/edge interrupt wires into a one-at-a-time
// request/complete handshake. Define IRQ_GATEWAY_RX_SYNC_EN to add input synchronizers.
module irq_gateway_rx #(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_PEND    = 3,
    localparam int ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int CNT_W      = $clog2(MAX_PEND + 1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] edge_mode,
    output logic               req_valid,
    output logic [ID_W-1:0]    req_id,
    input  logic               req_ready,
    input  logic               cmpl_valid,
    input  logic [ID_W-1:0]    cmpl_id,
    output logic [NUM_SRC-1:0] inflight
);

    // Handshake: the offer (req_valid/req_id) is registered and held until
    // req_valid && req_ready; a completion is a single-cycle cmpl_valid strobe.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_INFL = 2'd2
    } src_state_t;

    if (NUM_SRC < 1 || NUM_SRC > 32 || MAX_PEND < 1 || MAX_PEND > 15 || SYNC_STAGES < 2) begin : g_bad_param
        $error("irq_gateway_rx: parameter out of range");
    end

    src_state_t         state_q [NUM_SRC];
    logic [CNT_W-1:0]   cnt_q   [NUM_SRC];
    logic [CNT_W-1:0]   cnt_nxt [NUM_SRC];
    logic [NUM_SRC-1:0] mode_q;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] level;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eff_mode;
    logic [NUM_SRC-1:0] grant_hit;
    logic [NUM_SRC-1:0] cmpl_hit;
    logic               grant;
    logic               pick_valid;
    logic [ID_W-1:0]    pick_id;

`ifdef IRQ_GATEWAY_RX_SYNC_EN
    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
`else
    assign level = irq_in;
`endif

    assign rise  = level & ~prev_q;
    assign grant = req_valid & req_ready;

    // Mode is taken live only while IDLE; once triggered, a source keeps the mode it started with.
    always_comb begin
        eff_mode  = '0;
        grant_hit = '0;
        cmpl_hit  = '0;
        inflight  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eff_mode[i]  = (state_q[i] == ST_IDLE) ? edge_mode[i] : mode_q[i];
            grant_hit[i] = grant && (req_id == ID_W'(i));
            cmpl_hit[i]  = cmpl_valid && (cmpl_id == ID_W'(i)) && (state_q[i] == ST_INFL);
            inflight[i]  = (state_q[i] == ST_INFL);
        end
    end

    // Edge counter: an edge coinciding with a grant cancels out, even at saturation.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            cnt_nxt[i] = cnt_q[i];
            if (!eff_mode[i]) begin
                cnt_nxt[i] = '0;
            end else if (rise[i] && !grant_hit[i]) begin
                if (cnt_q[i] != CNT_W'(MAX_PEND)) begin
                    cnt_nxt[i] = cnt_q[i] + 1'b1;
                end
            end else if (grant_hit[i] && !rise[i]) begin
                cnt_nxt[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (state_q[i] == ST_PEND) begin
                pick_valid = 1'b1;
                pick_id    = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            mode_q    <= '0;
            prev_q    <= '0;
            req_valid <= 1'b0;
            req_id    <= '0;
        end else begin
            prev_q <= level;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= cnt_nxt[i];
                if (state_q[i] == ST_IDLE) begin
                    mode_q[i] <= edge_mode[i];
                end
                case (state_q[i])
                    ST_IDLE: begin
                        if (eff_mode[i] ? (cnt_nxt[i] != '0) : level[i]) begin
                            state_q[i] <= ST_PEND;
                        end
                    end
                    ST_PEND: begin
                        if (grant_hit[i]) begin
                            state_q[i] <= ST_INFL;
                        end
                    end
                    ST_INFL: begin
                        if (cmpl_hit[i]) begin
                            state_q[i] <= ST_IDLE;
                        end
                    end
                    default: state_q[i] <= ST_IDLE;
                endcase
            end
            // A grant always drops the offer, which forces a one-cycle gap before the next one.
            if (req_valid) begin
                if (req_ready) begin
                    req_valid <= 1'b0;
                end
            end else if (pick_valid) begin
                req_valid <= 1'b1;
                req_id    <= pick_id;
            end
        end
    end

endmodule

// File: tb/tb_irq_gateway_rx.sv
// Bench for irq_gateway_rx: directed scenarios followed by random traffic, every cycle
// compared against a behavioural model of the gateway's claim rules.
module tb_irq_gateway_rx;

    localparam int N  = 4;
    localparam int SS = 2;
    localparam int MP = 3;
`ifdef IRQ_GATEWAY_RX_SYNC_EN
    localparam int SD = SS;
`else
    localparam int SD = 0;
`endif
    localparam int LAT = SD + 2;

    logic         clock;
    logic         reset_n;
    logic [N-1:0] irq_in;
    logic [N-1:0] edge_mode;
    logic         req_valid;
    logic [1:0]   req_id;
    logic         req_ready;
    logic         cmpl_valid;
    logic [1:0]   cmpl_id;
    logic [N-1:0] inflight;

    int checks = 0;
    int errors = 0;
    int grants;

    // model: a source is idle, waiting for a claim, or claimed
    bit m_wait  [N];
    bit m_claim [N];
    bit m_mode  [N];
    bit m_prev  [N];
    int m_cnt   [N];
    bit m_rv;
    int m_rid;
`ifdef IRQ_GATEWAY_RX_SYNC_EN
    logic [N-1:0] pipe [$];
`endif

    irq_gateway_rx #(.NUM_SRC(N), .SYNC_STAGES(SS), .MAX_PEND(MP)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .irq_in     (irq_in),
        .edge_mode  (edge_mode),
        .req_valid  (req_valid),
        .req_id     (req_id),
        .req_ready  (req_ready),
        .cmpl_valid (cmpl_valid),
        .cmpl_id    (cmpl_id),
        .inflight   (inflight)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_wait[i] = 0; m_claim[i] = 0; m_mode[i] = 0; m_prev[i] = 0; m_cnt[i] = 0;
        end
        m_rv  = 0;
        m_rid = 0;
`ifdef IRQ_GATEWAY_RX_SYNC_EN
        pipe = {};
        for (int k = 0; k < SS; k++) pipe.push_back('0);
`endif
    endtask

    task automatic model_step(input logic [N-1:0] irq, input logic [N-1:0] em,
                              input logic rdy, input logic cv, input logic [1:0] cid);
        logic [N-1:0] s;
        bit n_wait [N];
        bit n_claim [N];
        bit idle, eff, rise, got_grant, got_cmpl;
        int n;
`ifdef IRQ_GATEWAY_RX_SYNC_EN
        s = pipe.pop_front();
        pipe.push_back(irq);
`else
        s = irq;
`endif
        for (int i = 0; i < N; i++) begin
            idle      = !m_wait[i] && !m_claim[i];
            eff       = idle ? em[i] : m_mode[i];
            rise      = s[i] && !m_prev[i];
            got_grant = m_rv && rdy && (m_rid == i);
            got_cmpl  = cv && (int'(cid) == i) && m_claim[i];
            n = eff ? m_cnt[i] + int'(rise) - int'(got_grant) : 0;
            if (n > MP) n = MP;
            m_cnt[i] = n;
            if (idle) begin
                n_wait[i]  = eff ? (n > 0) : s[i];
                n_claim[i] = 0;
            end else if (m_wait[i]) begin
                n_wait[i]  = !got_grant;
                n_claim[i] = got_grant;
            end else begin
                n_wait[i]  = 0;
                n_claim[i] = !got_cmpl;
            end
            m_mode[i] = eff;
            m_prev[i] = s[i];
        end
        if (m_rv) begin
            m_rv = !rdy;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_wait[i]) begin
                    m_rv  = 1;
                    m_rid = i;
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            m_wait[i]  = n_wait[i];
            m_claim[i] = n_claim[i];
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_infl;
        for (int i = 0; i < N; i++) exp_infl[i] = m_claim[i];
        chk("req_valid", {31'd0, req_valid}, {31'd0, m_rv});
        chk("req_id", {30'd0, req_id}, m_rid);
        chk("inflight", {28'd0, inflight}, {28'd0, exp_infl});
    endtask

    task automatic cycle(input logic [N-1:0] irq, input logic [N-1:0] em,
                         input logic rdy, input logic cv, input logic [1:0] cid);
        irq_in = irq; edge_mode = em; req_ready = rdy; cmpl_valid = cv; cmpl_id = cid;
        model_step(irq, em, rdy, cv, cid);
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        irq_in = '0; req_ready = 0; cmpl_valid = 0;
        #1;
        model_reset();
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_req_id", {30'd0, req_id}, 32'd0);
        chk("rst_inflight", {28'd0, inflight}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        irq_in = '0; edge_mode = '0; req_ready = 0; cmpl_valid = 0; cmpl_id = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_req_valid", {31'd0, req_valid}, 32'd0);
        chk("reset_req_id", {30'd0, req_id}, 32'd0);
        chk("reset_inflight", {28'd0, inflight}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // level basic: src2 held high
        repeat (LAT - 1) cycle(4'b0100, 4'b0000, 0, 0, 2'd0);
        chk("lvl_early", {31'd0, req_valid}, 32'd0);
        cycle(4'b0100, 4'b0000, 0, 0, 2'd0);
        chk("lvl_offer_valid", {31'd0, req_valid}, 32'd1);
        chk("lvl_offer_id", {30'd0, req_id}, 32'd2);
        cycle(4'b0100, 4'b0000, 1, 0, 2'd0);
        chk("lvl_inflight", {28'd0, inflight}, 32'h4);
        cycle(4'b0100, 4'b0000, 0, 1, 2'd2);
        chk("lvl_cmpl", {28'd0, inflight}, 32'h0);
        repeat (3) cycle(4'b0100, 4'b0000, 0, 0, 2'd0);
        chk("lvl_reoffer", {29'd0, req_valid, req_id}, 32'h6);
        cycle(4'b0000, 4'b0000, 1, 0, 2'd0);
        cycle(4'b0000, 4'b0000, 0, 1, 2'd2);

        // priority and hold
        repeat (LAT) cycle(4'b1000, 4'b0000, 0, 0, 2'd0);
        repeat (LAT + 2) cycle(4'b1001, 4'b0000, 0, 0, 2'd0);
        chk("prio_hold", {29'd0, req_valid, req_id}, 32'h7);
        cycle(4'b1001, 4'b0000, 1, 0, 2'd0);
        chk("prio_gap", {31'd0, req_valid}, 32'd0);
        cycle(4'b1001, 4'b0000, 0, 0, 2'd0);
        chk("prio_next", {29'd0, req_valid, req_id}, 32'h4);
        cycle(4'b0000, 4'b0000, 1, 0, 2'd0);
        repeat (SD) cycle(4'b0000, 4'b0000, 0, 0, 2'd0);
        cycle(4'b0000, 4'b0000, 0, 1, 2'd3);
        cycle(4'b0000, 4'b0000, 0, 1, 2'd0);

        // edge counting: five edges on src1, saturating at three
        for (int k = 0; k < 5; k++) begin
            cycle(4'b0010, 4'b0010, 0, 0, 2'd0);
            cycle(4'b0000, 4'b0010, 0, 0, 2'd0);
        end
        repeat (SD + 4) cycle(4'b0000, 4'b0010, 0, 0, 2'd0);
        grants = 0;
        for (int k = 0; k < 30; k++) begin
            if (req_valid) grants++;
            cycle(4'b0000, 4'b0010, 1, inflight[1], 2'd1);
        end
        chk("edge_grants", grants, 32'd3);
        chk("edge_quiet", {27'd0, req_valid, inflight}, 32'h0);

        // edge coinciding with grant
        cycle(4'b0010, 4'b0010, 0, 0, 2'd0);
        repeat (SD + 3) cycle(4'b0000, 4'b0010, 0, 0, 2'd0);
        chk("eg_offer", {29'd0, req_valid, req_id}, 32'h5);
        for (int k = 0; k <= SD; k++) cycle(4'b0010, 4'b0010, (k == SD), 0, 2'd0);
        cycle(4'b0010, 4'b0010, 0, 1, 2'd1);
        repeat (2) cycle(4'b0010, 4'b0010, 0, 0, 2'd0);
        chk("eg_reoffer", {29'd0, req_valid, req_id}, 32'h5);
        cycle(4'b0010, 4'b0010, 1, 0, 2'd0);
        cycle(4'b0010, 4'b0010, 0, 1, 2'd1);
        repeat (5) cycle(4'b0010, 4'b0010, 0, 0, 2'd0);
        chk("eg_drained", {27'd0, req_valid, inflight}, 32'h0);

        // bogus completions while src1 is claimed in level mode
        repeat (LAT) cycle(4'b0010, 4'b0000, 0, 0, 2'd0);
        cycle(4'b0010, 4'b0000, 1, 0, 2'd0);
        cycle(4'b0010, 4'b0000, 0, 1, 2'd0);
        chk("bogus_idle0", {28'd0, inflight}, 32'h2);
        cycle(4'b0010, 4'b0000, 0, 1, 2'd3);
        cycle(4'b0010, 4'b0000, 0, 1, 2'd2);
        chk("bogus_keep", {27'd0, req_valid, inflight}, 32'h2);
        repeat (SD + 1) cycle(4'b0000, 4'b0000, 0, 0, 2'd0);
        cycle(4'b0000, 4'b0000, 0, 1, 2'd1);
        chk("bogus_real", {28'd0, inflight}, 32'h0);

        // reset mid-flight: src0 claimed, src2 pending and offered
        repeat (LAT) cycle(4'b0001, 4'b0000, 0, 0, 2'd0);
        cycle(4'b0001, 4'b0000, 1, 0, 2'd0);
        repeat (LAT + 1) cycle(4'b0101, 4'b0000, 0, 0, 2'd0);
        chk("mid_before", {27'd0, req_valid, inflight}, 32'h11);
        pulse_reset();
        cycle(4'b0000, 4'b0000, 0, 1, 2'd0);
        chk("mid_after", {27'd0, req_valid, inflight}, 32'h0);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            if (k % 50 == 0) edge_mode = 4'($urandom_range(0, 15));
            cycle(4'($urandom_range(0, 15)), edge_mode, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
